// File: rtl/branch_trace_scorer.sv
// branch_trace_scorer: replays a recorded branch trace from a synchronous ROM
// into a branch predictor and grades each prediction against the true outcome.
// It presents one trace entry at a time (fetch, present for LAT cycles, update)
// and accumulates saturating hit/miss statistics for later readout.
module branch_trace_scorer #(
    parameter int AW  = 10,
    parameter int LAT = 1,
    parameter int CW  = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   num_branches,
    output logic [AW-1:0] trace_addr,
    input  logic [31:0]   trace_pc,
    input  logic          trace_taken,
    output logic [31:0]   PC,
    output logic          result,
    input  logic          branch,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] total_cnt,
    output logic [CW-1:0] miss_cnt,
    output logic [CW-1:0] taken_cnt,
    output logic [15:0]   max_streak
);

    localparam int             LCW     = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [LCW-1:0] LAT_TOP = LCW'(LAT - 1);
    localparam logic [AW:0]    MAX_N   = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_UPDATE,
        S_FINISH
    } state_t;

    state_t         state;
    state_t         next_state;

    logic [AW:0]    num_r;        // entries in this run, already clamped
    logic [AW:0]    idx;          // entry currently being graded
    logic [AW:0]    idx_next;
    logic [AW:0]    num_clamped;
    logic [LCW-1:0] lat_cnt;      // PRESENT countdown, LAT-1 down to 0
    logic           taken_r;      // true outcome of the entry being graded
    logic [15:0]    cur_streak;   // current run of consecutive misses
    logic [15:0]    streak_inc;
    logic           last_entry;
    logic           miss;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
        logic [CW-1:0] r;
        r = v;
        if (en && (v != {CW{1'b1}})) begin
            r = v + CW'(1);
        end
        return r;
    endfunction

    assign idx_next    = idx + (AW+1)'(1);
    assign last_entry  = (idx_next == num_r);
    assign miss        = branch ^ taken_r;
    assign streak_inc  = (cur_streak == 16'hFFFF) ? cur_streak : cur_streak + 16'd1;
    // A request longer than the trace replays the whole trace once, never wrapping.
    assign num_clamped = (num_branches > MAX_N) ? MAX_N : num_branches;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the status outputs that follow directly from state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        result     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (num_branches == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                busy       = 1'b1;
                next_state = S_PRESENT;
            end
            S_PRESENT: begin
                busy = 1'b1;
                if (lat_cnt == '0) begin
                    next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busy       = 1'b1;
                result     = taken_r;
                next_state = last_entry ? S_FINISH : S_FETCH;
            end
            S_FINISH: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: run setup, trace fetch/present, and statistics accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_addr <= '0;
            PC         <= '0;
            taken_r    <= 1'b0;
            num_r      <= '0;
            idx        <= '0;
            lat_cnt    <= '0;
            total_cnt  <= '0;
            miss_cnt   <= '0;
            taken_cnt  <= '0;
            cur_streak <= '0;
            max_streak <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_r      <= num_clamped;
                        idx        <= '0;
                        total_cnt  <= '0;
                        miss_cnt   <= '0;
                        taken_cnt  <= '0;
                        cur_streak <= '0;
                        max_streak <= '0;
                        // An empty run touches no trace entry at all.
                        if (num_branches != '0) begin
                            trace_addr <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    lat_cnt <= LAT_TOP;
                end
                S_PRESENT: begin
                    // ROM data is valid in the first PRESENT cycle only.
                    if (lat_cnt == LAT_TOP) begin
                        PC      <= trace_pc;
                        taken_r <= trace_taken;
                    end
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LCW'(1);
                    end
                end
                S_UPDATE: begin
                    total_cnt <= sat_inc(total_cnt, 1'b1);
                    taken_cnt <= sat_inc(taken_cnt, taken_r);
                    miss_cnt  <= sat_inc(miss_cnt, miss);
                    if (miss) begin
                        cur_streak <= streak_inc;
                        if (streak_inc > max_streak) begin
                            max_streak <= streak_inc;
                        end
                    end else begin
                        cur_streak <= '0;
                    end
                    idx <= idx_next;
                    // Address stays on the final entry so it never wraps.
                    if (!last_entry) begin
                        trace_addr <= idx_next[AW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_trace_scorer.sv
// tb_branch_trace_scorer: drives branch_trace_scorer with a synchronous trace
// ROM and a simple predictor model, compares per-entry PC/result through a
// scoreboard queue and final statistics against a table of expected values.
module tb_branch_trace_scorer;

    localparam int AW    = 5;
    localparam int LAT   = 1;
    localparam int CW    = 4;
    localparam int P     = LAT + 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   num_branches;
    logic [AW-1:0] trace_addr;
    logic [31:0]   trace_pc;
    logic          trace_taken;
    logic [31:0]   PC;
    logic          result;
    logic          branch;
    logic          busy;
    logic          done;
    logic [CW-1:0] total_cnt;
    logic [CW-1:0] miss_cnt;
    logic [CW-1:0] taken_cnt;
    logic [15:0]   max_streak;

    branch_trace_scorer #(.AW(AW), .LAT(LAT), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_branches (num_branches),
        .trace_addr   (trace_addr),
        .trace_pc     (trace_pc),
        .trace_taken  (trace_taken),
        .PC           (PC),
        .result       (result),
        .branch       (branch),
        .busy         (busy),
        .done         (done),
        .total_cnt    (total_cnt),
        .miss_cnt     (miss_cnt),
        .taken_cnt    (taken_cnt),
        .max_streak   (max_streak)
    );

    always #5 clk = ~clk;

    // Trace ROM and predictor model contents.
    logic [31:0] rom_pc   [DEPTH];
    logic        rom_tk   [DEPTH];
    logic        pred_tab [DEPTH];
    int          bmode;   // 0: predict not-taken, 1: predict taken, 2: per-PC table

    // Synchronous ROM: data one cycle after address.
    always @(posedge clk) begin
        trace_pc    <= rom_pc[trace_addr];
        trace_taken <= rom_tk[trace_addr];
    end

    // Predictor model: prediction from the PC currently presented.
    always_comb begin
        case (bmode)
            0:       branch = 1'b0;
            1:       branch = 1'b1;
            default: branch = pred_tab[PC[AW+1:2]];
        endcase
    end

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          n;
        int          bmode;
        logic [31:0] taken_bits;
        logic [31:0] pred_bits;
        bit          spam;       // hold start high for the whole run incl. done
        int          e_total;
        int          e_miss;
        int          e_taken;
        int          e_streak;
        int          e_addr;     // trace_addr left after the run
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    task automatic load_trace(input vec_t v);
        for (int i = 0; i < DEPTH; i++) begin
            rom_pc[i]   = 32'hC0DE_0000 | (32'(i) << 2);
            rom_tk[i]   = v.taken_bits[i];
            pred_tab[i] = v.pred_bits[i];
        end
        bmode = v.bmode;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int          nc;
        int          len;
        int          k;
        int          ph;
        int          flag_err;
        logic [31:0] last_pc;
        exp_t        e;
        nc       = (v.n > DEPTH) ? DEPTH : v.n;
        len      = nc * P + 1;
        flag_err = 0;
        last_pc  = '0;
        load_trace(v);
        for (int i = 0; i < nc; i++) begin
            sb.push_back('{rom_pc[i], rom_tk[i]});
        end
        @(negedge clk);
        start        = 1'b1;
        num_branches = v.n[AW:0];
        @(posedge clk);
        #1 start = v.spam;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (c < len) begin
                if (!busy || done) flag_err++;
                k  = (c - 1) / P;
                ph = (c - 1) % P;
                if (ph == 0) begin
                    if (result) flag_err++;
                    check($sformatf("v%0d fetch_addr[%0d]", id, k), 32'(trace_addr), 32'(k));
                    if (k > 0) check($sformatf("v%0d pc_hold[%0d]", id, k), PC, last_pc);
                end
                if (ph == P - 1) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_bad++;
                        $display("FAIL v%0d scoreboard: update with no entry expected (cycle %0d)", id, c);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("v%0d update_pc[%0d]", id, k), PC, e.pc);
                        check($sformatf("v%0d update_result[%0d]", id, k), 32'(result), 32'(e.tk));
                        last_pc = e.pc;
                    end
                end
            end else begin
                check($sformatf("v%0d done_at_%0d", id, len), 32'(done), 32'd1);
                check($sformatf("v%0d busy_at_done", id), 32'(busy), 32'd0);
                start = 1'b0;
            end
        end
        check($sformatf("v%0d in_run_status_errors", id), 32'(flag_err), 32'd0);
        check($sformatf("v%0d scoreboard_left", id), 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clk);
        check($sformatf("v%0d done_one_cycle", id), 32'(done), 32'd0);
        check($sformatf("v%0d busy_idle", id), 32'(busy), 32'd0);
        check($sformatf("v%0d total_cnt", id), 32'(total_cnt), 32'(v.e_total));
        check($sformatf("v%0d miss_cnt", id), 32'(miss_cnt), 32'(v.e_miss));
        check($sformatf("v%0d taken_cnt", id), 32'(taken_cnt), 32'(v.e_taken));
        check($sformatf("v%0d max_streak", id), 32'(max_streak), 32'(v.e_streak));
        check($sformatf("v%0d final_addr", id), 32'(trace_addr), 32'(v.e_addr));
    endtask

    // Reset asserted while entry index 2 is in PRESENT, then a fresh run.
    task automatic reset_mid_run();
        int flag_err;
        flag_err = 0;
        load_trace(vecs[2]);
        @(negedge clk);
        start        = 1'b1;
        num_branches = 7'(6);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3 * 2 + 2) @(negedge clk);
        check("mid busy_before_reset", 32'(busy), 32'd1);
        check("mid total_before_reset", 32'(total_cnt), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid busy_after_reset", 32'(busy), 32'd0);
        check("mid done_after_reset", 32'(done), 32'd0);
        check("mid total_after_reset", 32'(total_cnt), 32'd0);
        check("mid miss_after_reset", 32'(miss_cnt), 32'd0);
        check("mid taken_after_reset", 32'(taken_cnt), 32'd0);
        check("mid streak_after_reset", 32'(max_streak), 32'd0);
        check("mid addr_after_reset", 32'(trace_addr), 32'd0);
        check("mid pc_after_reset", PC, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) flag_err++;
        end
        check("mid no_done_after_reset", 32'(flag_err), 32'd0);
        run_vec(8, vecs[1]);
    endtask

    initial begin
        //            n   bm taken          pred          spm tot mis tkn stk addr
        vecs[0] = '{  0, 1, 32'h0,         32'h0,        0,  0,  0,  0,  0,  0 };
        vecs[1] = '{  4, 1, 32'hB,         32'h0,        0,  4,  1,  3,  1,  3 };
        vecs[2] = '{  6, 0, 32'h3F,        32'h0,        0,  6,  6,  6,  6,  5 };
        vecs[3] = '{  5, 2, 32'h0D,        32'h03,       0,  5,  3,  3,  3,  4 };
        vecs[4] = '{  4, 2, 32'h0,         32'hB,        0,  4,  3,  0,  2,  3 };
        vecs[5] = '{ 20, 0, 32'hF_FFFF,    32'h0,        0, 15, 15, 15, 20, 19 };
        vecs[6] = '{ 40, 1, 32'h0000_FFFF, 32'h0,        0, 15, 15, 15, 16, 31 };
        vecs[7] = '{  7, 2, 32'h55,        32'h35,       1,  7,  2,  4,  2,  6 };

        reset        = 1'b1;
        start        = 1'b0;
        num_branches = '0;
        load_trace(vecs[0]);
        repeat (2) @(negedge clk);
        check("reset trace_addr", 32'(trace_addr), 32'd0);
        check("reset PC", PC, 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset total_cnt", 32'(total_cnt), 32'd0);
        check("reset miss_cnt", 32'(miss_cnt), 32'd0);
        check("reset taken_cnt", 32'(taken_cnt), 32'd0);
        check("reset max_streak", 32'(max_streak), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);
        check("idle done", 32'(done), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        reset_mid_run();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
